// File: rtl/riscv_wb_arbiter.sv
// rtl/riscv_wb_arbiter.sv - two-source round-robin writeback arbiter for the register file write port
module riscv_wb_arbiter #(
  parameter int WORD_LENGTH = 32,
  parameter int ADDR_LENGTH = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   s0_valid,
  output logic                   s0_ready,
  input  logic [ADDR_LENGTH-1:0] s0_addr,
  input  logic [WORD_LENGTH-1:0] s0_data,
  input  logic                   s1_valid,
  output logic                   s1_ready,
  input  logic [ADDR_LENGTH-1:0] s1_addr,
  input  logic [WORD_LENGTH-1:0] s1_data,
  output logic                   write_en,
  output logic [ADDR_LENGTH-1:0] write_addr,
  output logic [WORD_LENGTH-1:0] write_data,
  output logic                   busy
);

  // One-entry holding register per source
  logic                   held0, held1;
  logic [ADDR_LENGTH-1:0] addr0, addr1;
  logic [WORD_LENGTH-1:0] data0, data1;

  // Round-robin pointer: 0 favours the ALU, 1 favours the load unit on a tie
  logic                   ptr;

  logic                   retire0, retire1;
  logic                   hs0, hs1;
  logic [ADDR_LENGTH-1:0] sel_addr;
  logic [WORD_LENGTH-1:0] sel_data;

  // Pick the entry to retire this cycle and mux its fields
  always_comb begin
    retire0  = held0 & (~held1 | ~ptr);
    retire1  = held1 & (~held0 | ptr);
    sel_addr = retire1 ? addr1 : addr0;
    sel_data = retire1 ? data1 : data0;
  end

  // A slot is free if empty or being drained this cycle; independent of valid
  assign s0_ready = ~held0 | retire0;
  assign s1_ready = ~held1 | retire1;
  assign hs0      = s0_valid & s0_ready;
  assign hs1      = s1_valid & s1_ready;
  assign busy     = held0 | held1 | write_en;

  // Holding registers, pointer and registered write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held0      <= 1'b0;
      held1      <= 1'b0;
      addr0      <= '0;
      addr1      <= '0;
      data0      <= '0;
      data1      <= '0;
      ptr        <= 1'b0;
      write_en   <= 1'b0;
      write_addr <= '0;
      write_data <= '0;
    end else begin
      if (hs0) begin
        held0 <= 1'b1;
        addr0 <= s0_addr;
        data0 <= s0_data;
      end else if (retire0) begin
        held0 <= 1'b0;
      end

      if (hs1) begin
        held1 <= 1'b1;
        addr1 <= s1_addr;
        data1 <= s1_data;
      end else if (retire1) begin
        held1 <= 1'b0;
      end

      // Only a contested retire moves the pointer, away from the winner
      if (held0 & held1) begin
        ptr <= ~ptr;
      end

      if (retire0 | retire1) begin
        write_en   <= (sel_addr != '0);
        write_addr <= sel_addr;
        write_data <= sel_data;
      end else begin
        write_en   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_riscv_wb_arbiter.sv
// tb/tb_riscv_wb_arbiter.sv - scoreboard bench for riscv_wb_arbiter with a transaction-level reference model
module tb_riscv_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        s0_valid, s1_valid;
  logic        s0_ready, s1_ready;
  logic [4:0]  s0_addr, s1_addr;
  logic [31:0] s0_data, s1_data;
  logic        write_en;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic        busy;

  riscv_wb_arbiter #(.WORD_LENGTH(32), .ADDR_LENGTH(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_addr(s0_addr), .s0_data(s0_data),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_addr(s1_addr), .s1_data(s1_data),
    .write_en(write_en), .write_addr(write_addr), .write_data(write_data), .busy(busy)
  );

  typedef struct {
    int          stamp;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t expq[$];
  exp_t mon_e;

  int checks = 0;
  int passed = 0;
  int cyc    = 0;

  // Reference model: pending entry per source, fairness pointer, last write enable
  bit          mh[2];
  logic [4:0]  ma[2];
  logic [31:0] md[2];
  int          mrr;
  bit          mwe;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    else passed++;
  endtask

  task automatic drive(input bit v0, input int a0, input int d0, input bit v1, input int a1, input int d1);
    s0_valid = v0; s0_addr = a0[4:0]; s0_data = d0;
    s1_valid = v1; s1_addr = a1[4:0]; s1_data = d1;
  endtask

  task automatic model_clear();
    mh[0] = 0; mh[1] = 0; mrr = 0; mwe = 0;
    expq.delete();
  endtask

  // One clock: check handshake outputs against the model, advance the model
  task automatic step();
    int win;
    bit r0, r1;
    @(negedge clk); #1;
    win = -1;
    if (mh[0] && mh[1]) win = mrr;
    else if (mh[0])     win = 0;
    else if (mh[1])     win = 1;
    r0 = !mh[0] || (win == 0);
    r1 = !mh[1] || (win == 1);
    chk("s0_ready", s0_ready, r0);
    chk("s1_ready", s1_ready, r1);
    chk("busy", busy, mh[0] | mh[1] | mwe);
    if (win >= 0) begin
      if (mh[0] && mh[1]) mrr = 1 - win;
      mwe = (ma[win] != 0);
      if (mwe) expq.push_back('{cyc + 1, ma[win], md[win]});
      mh[win] = 0;
    end else begin
      mwe = 0;
    end
    if (s0_valid && r0) begin mh[0] = 1; ma[0] = s0_addr; md[0] = s0_data; end
    if (s1_valid && r1) begin mh[1] = 1; ma[1] = s1_addr; md[1] = s1_data; end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic mid_reset();
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("rst_write_en", write_en, 0);
    chk("rst_write_addr", write_addr, 0);
    chk("rst_write_data", write_data, 0);
    chk("rst_s0_ready", s0_ready, 1);
    chk("rst_s1_ready", s1_ready, 1);
    model_clear();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Monitor: every visible write must match the oldest expected write, on time
  always @(negedge clk) begin
    if (rst_n) begin
      if (write_en) begin
        if (expq.size() == 0) begin
          chk("unexpected_write", write_en, 0);
        end else begin
          mon_e = expq.pop_front();
          chk("write_cycle", cyc, mon_e.stamp);
          chk("write_addr", write_addr, mon_e.addr);
          chk("write_data", write_data, mon_e.data);
        end
      end else if (expq.size() > 0 && expq[0].stamp <= cyc) begin
        chk("missing_write", write_en, 1);
        void'(expq.pop_front());
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_write_en", write_en, 0);
    chk("reset_write_addr", write_addr, 0);
    chk("reset_write_data", write_data, 0);
    chk("reset_busy", busy, 0);
    rst_n = 1'b1;
    idle(2);

    // Single ALU write
    drive(1, 5, 32'hDEADBEEF, 0, 0, 0);
    step();
    idle(4);

    // Simultaneous arrival: ALU first, load next cycle
    drive(1, 3, 32'h11, 1, 4, 32'h22);
    step();
    drive(0, 0, 0, 1, 4, 32'h22);
    step();
    idle(4);

    // Sustained contention with incrementing data
    for (int i = 0; i < 6; i++) begin
      drive(1, 3, 32'h100 + i, 1, 4, 32'h200 + i);
      step();
    end
    idle(4);

    // x0 result is consumed but never written
    drive(0, 0, 0, 1, 0, 32'hFFFFFFFF);
    step();
    idle(4);

    // Reset while both entries are held
    drive(1, 7, 32'hAAAA, 1, 8, 32'hBBBB);
    step();
    drive(0, 0, 0, 0, 0, 0);
    mid_reset();
    idle(4);

    // Back-to-back single source
    for (int i = 1; i <= 4; i++) begin
      drive(1, i, 32'h1000 + i, 0, 0, 0);
      step();
    end
    idle(4);

    // Randomized traffic, x0 included
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 31), $urandom,
            $urandom_range(0, 2) != 0, $urandom_range(0, 31), $urandom);
      step();
    end
    idle(5);

    chk("all_writes_seen", expq.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
